// File: rtl/sr_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : sr_bank_if
// Brief    : Requester/bank signal bundle for the SR-bank controller.
// Revision : 1.0 - initial release
// ============================================================================
interface sr_bank_if #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3
);
    logic [NREQ-1:0]      req_valid;
    logic [2*NREQ-1:0]    req_op;
    logic [IDXW*NREQ-1:0] req_idx;
    logic [NREQ-1:0]      req_ready;
    logic                 req_err;
    logic [NFLAG-1:0]     s_vec;
    logic [NFLAG-1:0]     r_vec;
    logic [NFLAG-1:0]     flag_q;
    logic                 busy;

    modport master (
        output req_valid, req_op, req_idx,
        input  req_ready, req_err, s_vec, r_vec, flag_q, busy
    );

    modport slave (
        input  req_valid, req_op, req_idx,
        output req_ready, req_err, s_vec, r_vec, flag_q, busy
    );
endinterface
`default_nettype wire

// File: rtl/sr_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sr_bank_ctrl
// Brief    : Round-robin arbiter driving one-hot S/R pulses into an SR bank.
// Revision : 1.0 - initial release
// ============================================================================
module sr_bank_ctrl #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3
) (
    input  wire logic CLK,
    input  wire logic RST_N,
    sr_bank_if.slave  bus
);
    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t             r_state;
    logic [PTRW-1:0]    r_ptr;
    logic [PTRW-1:0]    r_gnt;
    logic [1:0]         r_op;
    logic [IDXW-1:0]    r_idx;
    logic               r_err_pend;
    logic [NREQ-1:0]    r_ready;
    logic               r_err;
    logic [NFLAG-1:0]   r_s;
    logic [NFLAG-1:0]   r_r;
    logic [NFLAG-1:0]   r_flag;
    logic               r_busy;

    logic [NREQ-1:0]    w_valid;
    logic [2*NREQ-1:0]  w_rot2;
    logic               w_found;
    logic [PTRW-1:0]    w_gnt;
    logic [1:0]         w_op;
    logic [IDXW-1:0]    w_idx;
    logic [NFLAG-1:0]   w_hit;

    // A requester whose ack is visible this cycle still shows its old valid.
    assign w_valid = bus.req_valid & ~r_ready;
    assign w_rot2  = {w_valid, w_valid} >> r_ptr;

    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot2[i]) begin
                w_found = 1'b1;
                w_gnt   = PTRW'((int'(r_ptr) + i) % NREQ);
            end
        end
    end

    always_comb begin
        w_op  = '0;
        w_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (PTRW'(k) == w_gnt) begin
                w_op  = bus.req_op[2*k +: 2];
                w_idx = bus.req_idx[IDXW*k +: IDXW];
            end
        end
    end

    // Out-of-range indices shift the bit off the end, so no flop is hit.
    assign w_hit = (r_op == 2'b00) ? '0 : (NFLAG'(1) << r_idx);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_op       <= '0;
            r_idx      <= '0;
            r_err_pend <= 1'b0;
            r_ready    <= '0;
            r_err      <= 1'b0;
            r_s        <= '0;
            r_r        <= '0;
            r_flag     <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_s     <= '0;
            r_r     <= '0;
            r_ready <= '0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= w_gnt;
                        r_op    <= w_op;
                        r_idx   <= w_idx;
                        r_busy  <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    case (r_op)
                        2'b01: begin
                            r_s    <= w_hit;
                            r_flag <= r_flag | w_hit;
                        end
                        2'b10: begin
                            r_r    <= w_hit;
                            r_flag <= r_flag & ~w_hit;
                        end
                        2'b11: begin
                            r_s    <= w_hit & ~r_flag;
                            r_r    <= w_hit & r_flag;
                            r_flag <= r_flag ^ w_hit;
                        end
                        default: ;
                    endcase
                    r_err_pend <= (w_hit == '0);
                    r_state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_ready <= NREQ'(1) << r_gnt;
                    r_err   <= r_err_pend;
                    r_ptr   <= PTRW'((int'(r_gnt) + 1) % NREQ);
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.req_err   = r_err;
    assign bus.s_vec     = r_s;
    assign bus.r_vec     = r_r;
    assign bus.flag_q    = r_flag;
    assign bus.busy      = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_sr_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_bank_ctrl
// Brief    : Self-checking bench for sr_bank_ctrl against a cycle-timed SR-bank model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_bank_ctrl;
    localparam int NREQ  = 4;
    localparam int NFLAG = 6;
    localparam int IDXW  = 3;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    sr_bank_if #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) bus ();

    sr_bank_ctrl #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    int ack_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: grant at edge g -> S/R pulse after edge g+1 -> ack after edge g+3;
    // next arbitration no earlier than edge g+4. The bank obeys S sets, R clears.
    int               e_cnt    = 0;
    int               g_edge   = -1000;
    int               next_arb = 0;
    int               m_ptr    = 0;
    int               m_id     = 0;
    int               m_idx;
    logic [1:0]       m_op;
    logic [NFLAG-1:0] m_flag, m_s, m_r;
    logic             m_err;
    logic [NFLAG-1:0] exp_s = '0, exp_r = '0;
    logic [NREQ-1:0]  exp_ready = '0;
    logic             exp_err = 1'b0, exp_busy = 1'b0;
    logic [NREQ-1:0]  cand;
    bit               found;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_flag    = '0;
            exp_s     = '0;
            exp_r     = '0;
            exp_ready = '0;
            exp_err   = 1'b0;
            exp_busy  = 1'b0;
            g_edge    = -1000;
            next_arb  = e_cnt;
            m_ptr     = 0;
        end else begin
            e_cnt++;
            if (e_cnt == g_edge + 1)
                m_flag = (m_flag | m_s) & ~m_r;
            if (e_cnt >= next_arb) begin
                cand  = bus.req_valid & ~exp_ready;
                found = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    int c;
                    c = (m_ptr + k) % NREQ;
                    if (!found && cand[c]) begin
                        found = 1'b1;
                        m_id  = c;
                    end
                end
                if (found) begin
                    g_edge = e_cnt;
                    m_op   = bus.req_op[2*m_id +: 2];
                    m_idx  = int'(bus.req_idx[IDXW*m_id +: IDXW]);
                    m_err  = (m_op == 2'b00) || (m_idx >= NFLAG);
                    m_s    = '0;
                    m_r    = '0;
                    if (!m_err) begin
                        if (m_op == 2'b01)      m_s[m_idx] = 1'b1;
                        else if (m_op == 2'b10) m_r[m_idx] = 1'b1;
                        else if (m_flag[m_idx]) m_r[m_idx] = 1'b1;
                        else                    m_s[m_idx] = 1'b1;
                    end
                    m_ptr    = (m_id + 1) % NREQ;
                    next_arb = e_cnt + 4;
                end
            end
            exp_s     = (e_cnt == g_edge + 1) ? m_s : '0;
            exp_r     = (e_cnt == g_edge + 1) ? m_r : '0;
            exp_ready = (e_cnt == g_edge + 3) ? (NREQ'(1) << m_id) : '0;
            exp_err   = (e_cnt == g_edge + 3) ? m_err : 1'b0;
            exp_busy  = (e_cnt >= g_edge) && (e_cnt < g_edge + 3);
        end
    end

    always @(negedge CLK) begin
        if (RST_N) begin
            chk("s_vec", bus.s_vec, exp_s);
            chk("r_vec", bus.r_vec, exp_r);
            chk("flag_q", bus.flag_q, m_flag);
            chk("req_ready", bus.req_ready, exp_ready);
            chk("busy", bus.busy, exp_busy);
            if (exp_ready != '0)
                chk("req_err", bus.req_err, exp_err);
            chk("s_and_r", bus.s_vec & bus.r_vec, 0);
            chk("sr_onehot", ($countones(bus.s_vec | bus.r_vec) <= 1), 1);
            chk("ready_onehot", ($countones(bus.req_ready) <= 1), 1);
        end
    end

    task automatic drive(input int k, input logic [1:0] op, input int idx);
        bus.req_valid[k]            = 1'b1;
        bus.req_op[2*k +: 2]        = op;
        bus.req_idx[IDXW*k +: IDXW] = IDXW'(idx);
    endtask

    task automatic single_op(input int k, input logic [1:0] op, input int idx,
                             input logic [NFLAG-1:0] xs, input logic [NFLAG-1:0] xr,
                             input logic [NFLAG-1:0] xflag, input logic xerr);
        @(negedge CLK);
        drive(k, op, idx);
        @(posedge CLK);
        @(negedge CLK); chk("lit_busy_grant", bus.busy, 1);
        @(negedge CLK); chk("lit_pulse_s", bus.s_vec, xs);
                        chk("lit_pulse_r", bus.r_vec, xr);
        @(negedge CLK); chk("lit_hold_sr", bus.s_vec | bus.r_vec, 0);
        @(negedge CLK); chk("lit_ready", bus.req_ready, NREQ'(1) << k);
                        chk("lit_err", bus.req_err, xerr);
                        chk("lit_flag", bus.flag_q, xflag);
        bus.req_valid[k] = 1'b0;
    endtask

    task automatic drain(input int budget, input int re_k, input logic [1:0] re_op, input int re_idx);
        int cyc     = 0;
        bit re_done = 1'b0;
        while ((bus.req_valid != '0 || bus.busy) && cyc < budget) begin
            @(negedge CLK);
            cyc++;
            for (int k = 0; k < NREQ; k++) begin
                if (bus.req_ready[k]) begin
                    ack_log.push_back(k);
                    if (k == re_k && !re_done) begin
                        re_done = 1'b1;
                        drive(k, re_op, re_idx);
                    end else begin
                        bus.req_valid[k] = 1'b0;
                    end
                end
            end
        end
        chk("drain_in_budget", (cyc < budget), 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 1};
        int acks;
        int cyc;

        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_idx   = '0;
        RST_N         = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_s_vec", bus.s_vec, 0);
        chk("rst_r_vec", bus.r_vec, 0);
        chk("rst_flag_q", bus.flag_q, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_busy", bus.busy, 0);
        RST_N = 1'b1;

        single_op(0, 2'b01, 5, 6'h20, 6'h00, 6'h20, 1'b0);
        single_op(1, 2'b11, 3, 6'h08, 6'h00, 6'h28, 1'b0);
        single_op(0, 2'b11, 3, 6'h00, 6'h08, 6'h20, 1'b0);
        single_op(2, 2'b00, 2, 6'h00, 6'h00, 6'h20, 1'b1);
        single_op(3, 2'b01, 7, 6'h00, 6'h00, 6'h20, 1'b1);

        // All four contend with the pointer at 0; requester 1 re-asserts on its ack.
        @(negedge CLK);
        ack_log.delete();
        drive(0, 2'b10, 5);
        drive(1, 2'b01, 0);
        drive(2, 2'b01, 1);
        drive(3, 2'b11, 2);
        drain(60, 1, 2'b01, 4);
        chk("contention_acks", ack_log.size(), 5);
        for (int i = 0; i < 5 && i < ack_log.size(); i++)
            chk("contention_order", ack_log[i], exp_order[i]);
        chk("contention_flag", bus.flag_q, 6'h17);

        // Reset while the pulse is on the bank.
        @(negedge CLK);
        drive(2, 2'b01, 1);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        chk("pre_rst_pulse", bus.s_vec, 6'h02);
        RST_N = 1'b0;
        #1;
        chk("midrst_s_vec", bus.s_vec, 0);
        chk("midrst_r_vec", bus.r_vec, 0);
        chk("midrst_flag_q", bus.flag_q, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_ready", bus.req_ready, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        ack_log.delete();
        drain(40, -1, 2'b00, 0);
        chk("post_rst_acks", ack_log.size(), 1);
        if (ack_log.size() > 0)
            chk("post_rst_ack_id", ack_log[0], 2);
        chk("post_rst_flag", bus.flag_q, 6'h02);

        acks = 0;
        cyc  = 0;
        while (acks < 10000 && cyc < 80000) begin
            @(negedge CLK);
            cyc++;
            for (int k = 0; k < NREQ; k++) begin
                if (bus.req_ready[k]) begin
                    acks++;
                    bus.req_valid[k] = 1'b0;
                end else if (!bus.req_valid[k] && $urandom_range(0, 1) == 1) begin
                    drive(k, 2'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
                end
            end
        end
        chk("soak_acks", acks, 10000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
